// File: rtl/final_project_pio_pkg.sv
// Shared definitions for the final_project PIO peripherals: s1 register
// addresses, edge-capture selectors and the per-bit edge classifier.
package final_project_pio_pkg;

   // s1 word addresses
   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

   // Which transition of the debounced level sets an edgecapture bit
   localparam logic [1:0] PIO_EDGE_RISE = 2'd0;
   localparam logic [1:0] PIO_EDGE_FALL = 2'd1;
   localparam logic [1:0] PIO_EDGE_ANY  = 2'd2;

   // True when the transition prev -> cur is the kind of edge being captured.
   function automatic logic pio_edge_hit(input logic       cur,
                                         input logic       prev,
                                         input logic [1:0] edge_type);
      logic hit;
      case (edge_type)
         PIO_EDGE_RISE: hit = cur & ~prev;
         PIO_EDGE_FALL: hit = ~cur & prev;
         PIO_EDGE_ANY:  hit = cur ^ prev;
         default:       hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a stability counter. The
// accepted level only moves after the synchronized input has disagreed with
// it for DEBOUNCE_CYCLES consecutive cycles. With DEBOUNCE_CYCLES == 0 the
// synchronizer output is the accepted level, so the only delay is the two
// synchronizer stages.
module pio_debounce_bit #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_bit,
   output logic stable
);

   logic meta_r;
   logic sync_r;

   // Two-stage synchronizer for the asynchronous input
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= in_bit;
         sync_r <= meta_r;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign stable = sync_r;
      end else begin : g_debounce
         localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

         logic [CNT_W-1:0] cnt_r;
         logic [CNT_W-1:0] cnt_nxt_s;
         logic             stable_r;
         logic             stable_nxt_s;

         // Count consecutive disagreeing cycles; accept the new level on the last one
         always_comb begin
            cnt_nxt_s    = cnt_r;
            stable_nxt_s = stable_r;
            if (sync_r == stable_r) begin
               cnt_nxt_s = {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
               stable_nxt_s = sync_r;
               cnt_nxt_s    = {CNT_W{1'b0}};
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end

         // Counter and accepted-level registers
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               cnt_r    <= {CNT_W{1'b0}};
               stable_r <= 1'b0;
            end else begin
               cnt_r    <= cnt_nxt_s;
               stable_r <= stable_nxt_s;
            end
         end

         assign stable = stable_r;
      end
   endgenerate

endmodule

// File: rtl/final_project_button_pio.sv
// Avalon-MM input PIO for buttons/switches. Each bit is synchronized and
// debounced, transitions of the debounced level are latched in a W1C
// edgecapture register, and irq is the OR of masked captured edges.
module final_project_button_pio
   import final_project_pio_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [1:0] EDGE_SEL = 2'(EDGE_TYPE);

   logic [WIDTH-1:0] stable_s;
   logic [WIDTH-1:0] stable_d_r;
   logic [WIDTH-1:0] edge_s;
   logic [WIDTH-1:0] clear_s;
   logic [WIDTH-1:0] edgecap_nxt_s;
   logic [WIDTH-1:0] edgecap_r;
   logic [WIDTH-1:0] irqmask_r;
   logic             wr_s;
   logic             unused_wdata_s;

   // Upper writedata bits have no home when WIDTH < 32
   assign unused_wdata_s = ^writedata;

   assign wr_s = chipselect & ~write_n;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .in_bit  (in_port[gi]),
            .stable  (stable_s[gi])
         );
      end
   endgenerate

   // Classify each bit's debounced transition against the selected edge type
   always_comb begin
      edge_s = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         edge_s[i] = pio_edge_hit(stable_s[i], stable_d_r[i], EDGE_SEL);
      end
   end

   // W1C clear mask and next edgecapture; a new edge beats a same-cycle clear
   always_comb begin
      if (wr_s && (address == PIO_ADDR_EDGE)) begin
         clear_s = writedata[WIDTH-1:0];
      end else begin
         clear_s = {WIDTH{1'b0}};
      end
      edgecap_nxt_s = (edgecap_r & ~clear_s) | edge_s;
   end

   // Delayed level, edgecapture and irqmask registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stable_d_r <= {WIDTH{1'b0}};
         edgecap_r  <= {WIDTH{1'b0}};
         irqmask_r  <= {WIDTH{1'b0}};
      end else begin
         stable_d_r <= stable_s;
         edgecap_r  <= edgecap_nxt_s;
         if (wr_s && (address == PIO_ADDR_IRQMASK)) begin
            irqmask_r <= writedata[WIDTH-1:0];
         end else begin
            irqmask_r <= irqmask_r;
         end
      end
   end

   // Zero-latency read mux; independent of chipselect and side-effect free
   always_comb begin
      readdata = 32'd0;
      case (address)
         PIO_ADDR_DATA:    readdata[WIDTH-1:0] = stable_s;
         PIO_ADDR_DIR:     readdata = 32'd0;
         PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_r;
         PIO_ADDR_EDGE:    readdata[WIDTH-1:0] = edgecap_r;
         default:          readdata = 32'd0;
      endcase
   end

   assign irq = |(edgecap_r & irqmask_r);

endmodule
